// File: rtl/muldiv_ctrl.sv
// rtl/muldiv_ctrl.sv - EX-stage multiply/divide sequencer with HI/LO writeback
//
// Purpose: accepts one mult/multu/div/divu from EX, latches the operands,
// drives an external multiplier (fixed latency MUL_LAT) or an external
// handshaked divider, stalls IF/ID/EX while busy, and presents the 64-bit
// result on hi_out/lo_out qualified by hilo_we.
//
// Ports:
//   clk, resetn                 clock, asynchronous active-low reset
//   op_valid, op_code, op_a/b   instruction from EX (00 mult, 01 multu, 10 div, 11 divu)
//   flush, hold                 kill in-flight op / downstream stall
//   stallreq                    pipeline stall request
//   hilo_we, hi_out, lo_out     HI/LO writeback
//   mul_signed, mul_ina/inb     multiplier operands, mul_result product
//   div_start, div_signed,
//   div_opdata1/2, div_annul    divider control, div_ready/div_result response
//
// Configuration: define MDU_DIVZERO_FAST_EN to complete divide-by-zero in one
// cycle (hi=dividend, lo=all ones) without starting the divider.
module muldiv_ctrl #(
  parameter int MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        op_valid,
  input  logic [1:0]  op_code,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        flush,
  input  logic        hold,
  output logic        stallreq,
  output logic        hilo_we,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output logic        mul_signed,
  output logic [31:0] mul_ina,
  output logic [31:0] mul_inb,
  input  logic [63:0] mul_result,
  output logic        div_start,
  output logic        div_signed,
  output logic [31:0] div_opdata1,
  output logic [31:0] div_opdata2,
  output logic        div_annul,
  input  logic        div_ready,
  input  logic [63:0] div_result
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic        sign_q;
  logic        div_zero_fast;

`ifdef MDU_DIVZERO_FAST_EN
  assign div_zero_fast = op_code[1] && (op_b == 32'd0);
`else
  assign div_zero_fast = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      a_q    <= 32'd0;
      b_q    <= 32'd0;
      sign_q <= 1'b0;
      hi_out <= 32'd0;
      lo_out <= 32'd0;
    end else if (flush) begin
      // Flush wins over any completion in the same cycle: no capture.
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (op_valid) begin
            a_q    <= op_a;
            b_q    <= op_b;
            sign_q <= ~op_code[0];
            if (div_zero_fast) begin
              hi_out <= op_a;
              lo_out <= 32'hFFFF_FFFF;
              state  <= DONE;
            end else if (!op_code[1]) begin
              cnt   <= 4'(MUL_LAT - 1);
              state <= MUL;
            end else begin
              state <= DIV;
            end
          end
        end
        MUL: begin
          if (cnt == 4'd0) begin
            {hi_out, lo_out} <= mul_result;
            state            <= DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DIV: begin
          if (div_ready) begin
            {hi_out, lo_out} <= div_result;
            state            <= DONE;
          end
        end
        DONE: begin
          if (!hold) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Operand buses are gated by state so the units see zeros when not in use;
  // the resetn term keeps every output low while reset is asserted.
  assign stallreq    = resetn && ((state == MUL) || (state == DIV) ||
                                  ((state == IDLE) && op_valid));
  assign hilo_we     = (state == DONE);
  assign mul_signed  = (state == MUL) && sign_q;
  assign mul_ina     = (state == MUL) ? a_q : 32'd0;
  assign mul_inb     = (state == MUL) ? b_q : 32'd0;
  assign div_signed  = (state == DIV) && sign_q;
  assign div_opdata1 = (state == DIV) ? a_q : 32'd0;
  assign div_opdata2 = (state == DIV) ? b_q : 32'd0;
  assign div_start   = (state == DIV) && !flush;
  assign div_annul   = (state == DIV) && flush;

endmodule
